// File: rtl/icache.sv
// Direct-mapped instruction cache with one outstanding BUS_LOAD miss and fill forwarding.
// Optional hit/miss counters are enabled with ICACHE_STATS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module icache #(
    parameter int unsigned LINES = 32,
    parameter int unsigned IDX_W = $clog2(LINES),
    parameter int unsigned TAG_W = `XLEN - 3 - IDX_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [`XLEN-1:0]   proc2Icache_addr,
    output logic [63:0]        Icache2proc_data,
    output logic               Icache2proc_valid,
    input  logic               mem_bus_free,
    output logic [1:0]         proc2Imem_command,
    output logic [`XLEN-1:0]   proc2Imem_addr,
    input  logic [3:0]         Imem2proc_response,
    input  logic [63:0]        Imem2proc_data,
    input  logic [3:0]         Imem2proc_tag
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [3:0]         pend_tag_q, pend_tag_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [63:0]        data_q [LINES];
    logic [TAG_W-1:0]   tag_q [LINES];

    logic [IDX_W-1:0]   cur_idx;
    logic [TAG_W-1:0]   cur_tag;
    logic               hit;
    logic               fill_done;
    logic               fwd;
    logic               fill_we;
    logic               unused_addr_lsb;

    assign cur_idx         = proc2Icache_addr[3+IDX_W-1:3];
    assign cur_tag         = proc2Icache_addr[`XLEN-1:3+IDX_W];
    assign unused_addr_lsb = ^proc2Icache_addr[2:0];

    assign hit       = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
    assign fill_done = (state_q == StWait) && (pend_tag_q != 4'd0)
                       && (Imem2proc_tag == pend_tag_q);
    assign fwd       = fill_done && (cur_idx == miss_idx_q) && (cur_tag == miss_tag_q);

    always_comb begin
        state_d           = state_q;
        miss_idx_d        = miss_idx_q;
        miss_tag_d        = miss_tag_q;
        pend_tag_d        = pend_tag_q;
        valid_d           = valid_q;
        fill_we           = 1'b0;
        proc2Imem_command = BUS_NONE;
        proc2Imem_addr    = '0;
        case (state_q)
            StIdle: begin
                if (!hit) begin
                    miss_idx_d = cur_idx;
                    miss_tag_d = cur_tag;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (mem_bus_free) begin
                    proc2Imem_command = BUS_LOAD;
                    proc2Imem_addr    = {miss_tag_q, miss_idx_q, 3'b000};
                    if (Imem2proc_response != 4'd0) begin
                        pend_tag_d = Imem2proc_response;
                        state_d    = StWait;
                    end
                end
            end
            StWait: begin
                if (fill_done) begin
                    fill_we             = 1'b1;
                    valid_d[miss_idx_q] = 1'b1;
                    pend_tag_d          = 4'd0;
                    state_d             = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Array hit takes priority; forwarding covers the fill cycle before the array is written.
    always_comb begin
        Icache2proc_valid = 1'b0;
        Icache2proc_data  = 64'd0;
        if (hit) begin
            Icache2proc_valid = 1'b1;
            Icache2proc_data  = data_q[cur_idx];
        end else if (fwd) begin
            Icache2proc_valid = 1'b1;
            Icache2proc_data  = Imem2proc_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            pend_tag_q <= 4'd0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            pend_tag_q <= pend_tag_d;
            valid_q    <= valid_d;
        end
    end

    // Data and tags are not reset; valid_q alone qualifies them.
    always_ff @(posedge clock) begin
        if (fill_we && !reset) begin
            data_q[miss_idx_q] <= Imem2proc_data;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [`XLEN-1:0] prev_addr_q, prev_addr_d;
    logic             prev_vld_q, prev_vld_d;
    logic [31:0]      hit_count_q, hit_count_d;
    logic [31:0]      miss_count_q, miss_count_d;

    always_comb begin
        prev_addr_d  = proc2Icache_addr;
        prev_vld_d   = 1'b1;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && (!prev_vld_q || (proc2Icache_addr != prev_addr_q))) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if ((state_q == StIdle) && (state_d == StReq)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_addr_q  <= '0;
            prev_vld_q   <= 1'b0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            prev_addr_q  <= prev_addr_d;
            prev_vld_q   <= prev_vld_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: memory-side stimulus with a scoreboard of expected fill data.
`ifndef XLEN
`define XLEN 32
`endif

module tb_icache;

    logic               clock;
    logic               reset;
    logic [`XLEN-1:0]   proc2Icache_addr;
    logic [63:0]        Icache2proc_data;
    logic               Icache2proc_valid;
    logic               mem_bus_free;
    logic [1:0]         proc2Imem_command;
    logic [`XLEN-1:0]   proc2Imem_addr;
    logic [3:0]         Imem2proc_response;
    logic [63:0]        Imem2proc_data;
    logic [3:0]         Imem2proc_tag;
`ifdef ICACHE_STATS_EN
    logic [31:0]        hit_count;
    logic [31:0]        miss_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    icache dut (
        .clock              (clock),
        .reset              (reset),
        .proc2Icache_addr   (proc2Icache_addr),
        .Icache2proc_data   (Icache2proc_data),
        .Icache2proc_valid  (Icache2proc_valid),
        .mem_bus_free       (mem_bus_free),
        .proc2Imem_command  (proc2Imem_command),
        .proc2Imem_addr     (proc2Imem_addr),
        .Imem2proc_response (Imem2proc_response),
        .Imem2proc_data     (Imem2proc_data),
        .Imem2proc_tag      (Imem2proc_tag)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {b ^ 32'hA5A5_0000, ~b};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Precondition: FSM idle and proc2Icache_addr == a, which misses.
    task automatic fill(input logic [31:0] a, input logic [3:0] rt, input int lat);
        logic [63:0] want;
        tick();
        mem_bus_free = 1'b1;
        Imem2proc_response = rt;
        #1;
        checks++;
        if (proc2Imem_command !== 2'd1) begin
            errors++;
            $display("FAIL fill_cmd %h: got %0d want 1", a, proc2Imem_command);
        end
        checks++;
        if (proc2Imem_addr !== {a[31:3], 3'b000}) begin
            errors++;
            $display("FAIL fill_addr: got %h want %h", proc2Imem_addr, {a[31:3], 3'b000});
        end
        exp_q.push_back(mem_word(a));
        tick();
        Imem2proc_response = 4'd0;
        for (int i = 1; i < lat; i++) begin
            #1;
            checks++;
            if (Icache2proc_valid !== 1'b0) begin
                errors++;
                $display("FAIL fill_wait_valid %h: got %b want 0", a, Icache2proc_valid);
            end
            tick();
        end
        Imem2proc_tag  = rt;
        Imem2proc_data = mem_word(a);
        #1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        checks++;
        if (Icache2proc_valid !== 1'b1 || Icache2proc_data !== want) begin
            errors++;
            $display("FAIL fill_fwd %h: got %b/%h want 1/%h", a, Icache2proc_valid,
                     Icache2proc_data, want);
        end
        tick();
        Imem2proc_tag  = 4'd0;
        Imem2proc_data = 64'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        proc2Icache_addr = 32'h100;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", Icache2proc_valid);
        end
        checks++;
        if (Icache2proc_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", Icache2proc_data);
        end
        checks++;
        if (proc2Imem_command !== 2'd0 || proc2Imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: got %0d/%h want 0/0", proc2Imem_command, proc2Imem_addr);
        end
    endtask

    task automatic test_cold_miss();
        fill(32'h100, 4'd3, 4);
        proc2Icache_addr = 32'h104;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b1 || Icache2proc_data !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL cold_rehit: got %b/%h want 1/%h", Icache2proc_valid,
                     Icache2proc_data, mem_word(32'h100));
        end
    endtask

    task automatic test_bus_busy();
        logic [63:0] want;
        proc2Icache_addr = 32'h300;
        tick();
        mem_bus_free = 1'b0;
        Imem2proc_response = 4'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (proc2Imem_command !== 2'd0 || proc2Imem_addr !== 32'd0) begin
                errors++;
                $display("FAIL busy_bus: got %0d/%h want 0/0", proc2Imem_command, proc2Imem_addr);
            end
            tick();
        end
        mem_bus_free = 1'b1;
        Imem2proc_response = 4'd0;
        #1;
        checks++;
        if (proc2Imem_command !== 2'd1 || proc2Imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL reject_bus: got %0d/%h want 1/300", proc2Imem_command, proc2Imem_addr);
        end
        tick();
        Imem2proc_response = 4'd5;
        #1;
        checks++;
        if (proc2Imem_command !== 2'd1 || proc2Imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL retry_bus: got %0d/%h want 1/300", proc2Imem_command, proc2Imem_addr);
        end
        exp_q.push_back(mem_word(32'h300));
        tick();
        Imem2proc_response = 4'd0;
        Imem2proc_tag = 4'd2;
        Imem2proc_data = 64'h1111_2222_3333_4444;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_tag_valid: got %b want 0", Icache2proc_valid);
        end
        tick();
        Imem2proc_tag = 4'd0;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b0 || proc2Imem_command !== 2'd0) begin
            errors++;
            $display("FAIL stray_tag_state: got %b/%0d want 0/0", Icache2proc_valid,
                     proc2Imem_command);
        end
        tick();
        Imem2proc_tag = 4'd5;
        Imem2proc_data = mem_word(32'h300);
        #1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        checks++;
        if (Icache2proc_valid !== 1'b1 || Icache2proc_data !== want) begin
            errors++;
            $display("FAIL busy_fill: got %b/%h want 1/%h", Icache2proc_valid,
                     Icache2proc_data, want);
        end
        tick();
        Imem2proc_tag = 4'd0;
        Imem2proc_data = 64'd0;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b1 || Icache2proc_data !== mem_word(32'h300)) begin
            errors++;
            $display("FAIL busy_rehit: got %b/%h want 1/%h", Icache2proc_valid,
                     Icache2proc_data, mem_word(32'h300));
        end
    endtask

    task automatic test_conflict();
        proc2Icache_addr = 32'h000;
        fill(32'h000, 4'd1, 2);
        proc2Icache_addr = 32'h100;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b0) begin
            errors++;
            $display("FAIL conflict_100_miss: got %b want 0", Icache2proc_valid);
        end
        fill(32'h100, 4'd2, 3);
        proc2Icache_addr = 32'h000;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b0) begin
            errors++;
            $display("FAIL conflict_000_evicted: got %b want 0", Icache2proc_valid);
        end
        fill(32'h000, 4'd4, 1);
    endtask

    task automatic test_hit_under_miss();
        proc2Icache_addr = 32'h008;
        fill(32'h008, 4'd6, 2);
        proc2Icache_addr = 32'h200;
        tick();
        mem_bus_free = 1'b1;
        Imem2proc_response = 4'd7;
        #1;
        checks++;
        if (proc2Imem_command !== 2'd1 || proc2Imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL hum_req: got %0d/%h want 1/200", proc2Imem_command, proc2Imem_addr);
        end
        tick();
        Imem2proc_response = 4'd0;
        proc2Icache_addr = 32'h008;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b1 || Icache2proc_data !== mem_word(32'h008)) begin
            errors++;
            $display("FAIL hum_hit: got %b/%h want 1/%h", Icache2proc_valid,
                     Icache2proc_data, mem_word(32'h008));
        end
        tick();
        tick();
        Imem2proc_tag = 4'd7;
        Imem2proc_data = mem_word(32'h200);
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b1 || Icache2proc_data !== mem_word(32'h008)) begin
            errors++;
            $display("FAIL hum_hit_during_fill: got %b/%h want 1/%h", Icache2proc_valid,
                     Icache2proc_data, mem_word(32'h008));
        end
        tick();
        Imem2proc_tag = 4'd0;
        Imem2proc_data = 64'd0;
        proc2Icache_addr = 32'h200;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b1 || Icache2proc_data !== mem_word(32'h200)) begin
            errors++;
            $display("FAIL hum_landed: got %b/%h want 1/%h", Icache2proc_valid,
                     Icache2proc_data, mem_word(32'h200));
        end
    endtask

    task automatic test_reset_mid_miss();
        logic [63:0] want;
        proc2Icache_addr = 32'h100;
        tick();
        mem_bus_free = 1'b1;
        Imem2proc_response = 4'd9;
        tick();
        Imem2proc_response = 4'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        Imem2proc_tag = 4'd9;
        Imem2proc_data = mem_word(32'h100);
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b0 || Icache2proc_data !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_out: got %b/%h want 0/0", Icache2proc_valid, Icache2proc_data);
        end
        checks++;
        if (proc2Imem_command !== 2'd0 || proc2Imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_bus: got %0d/%h want 0/0", proc2Imem_command, proc2Imem_addr);
        end
        tick();
        Imem2proc_tag = 4'd0;
        Imem2proc_data = 64'd0;
        mem_bus_free = 1'b0;
        proc2Icache_addr = 32'h008;
        #1;
        checks++;
        if (Icache2proc_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_lines_cleared: got %b want 0", Icache2proc_valid);
        end
        proc2Icache_addr = 32'h100;
        mem_bus_free = 1'b1;
        Imem2proc_response = 4'd8;
        #1;
        checks++;
        if (proc2Imem_command !== 2'd1 || proc2Imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL rst_mid_remiss: got %0d/%h want 1/100", proc2Imem_command,
                     proc2Imem_addr);
        end
        exp_q.push_back(mem_word(32'h100));
        tick();
        Imem2proc_response = 4'd0;
        tick();
        Imem2proc_tag = 4'd8;
        Imem2proc_data = mem_word(32'h100);
        #1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        checks++;
        if (Icache2proc_valid !== 1'b1 || Icache2proc_data !== want) begin
            errors++;
            $display("FAIL rst_mid_refill: got %b/%h want 1/%h", Icache2proc_valid,
                     Icache2proc_data, want);
        end
        tick();
        Imem2proc_tag = 4'd0;
        Imem2proc_data = 64'd0;
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        proc2Icache_addr = 32'h400;
        #1;
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d/%0d want 0/0", hit_count, miss_count);
        end
        fill(32'h400, 4'd3, 2);
        proc2Icache_addr = 32'h404;
        tick();
        proc2Icache_addr = 32'h400;
        tick();
        proc2Icache_addr = 32'h404;
        tick();
        #1;
        checks++;
        if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL stats_counts: got %0d/%0d want 3/1", hit_count, miss_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        proc2Icache_addr = '0;
        mem_bus_free = 1'b1;
        Imem2proc_response = 4'd0;
        Imem2proc_data = 64'd0;
        Imem2proc_tag = 4'd0;
        test_reset();
        test_cold_miss();
        test_bus_busy();
        test_conflict();
        test_hit_under_miss();
        test_reset_mid_miss();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
